wb_stage_gen: RTL and testbench

- Parametrised writeback stage: final pipeline stage of the in-order core.
- Registers the MEM-to-WB bus and retires instructions to the register file.
- Arbitrates exception causes into ecode/esubcode, drives the external CSR file, and issues a single-cycle pipeline flush with redirect target.
- Compared with the current WB stage, it adds:
  - configurable CSR read latency with stall;
  - suppression of register-file and CSR side effects for excepting instructions;
  - dropping of the younger instruction on flush;
  - synchronisation of asynchronous hardware interrupt lines.

---
 rtl/wb_stage_gen.sv | 189 ++++++++++++++++++
 tb/tb_wb_stage_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_gen.sv
// wb_stage_gen: final pipeline stage. It retires results to the GPR file,
// commits CSR side effects and exceptions, and redirects the pipeline on flush.
module wb_stage_gen #(
    parameter int DATA_W      = 32,
    parameter int NCAUSE      = 7,
    parameter int HWINT_W     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CSR_LAT     = 1,
    localparam int BUS_W      = 87 + 2 * DATA_W + NCAUSE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ms_to_ws_valid,
    input  logic [BUS_W-1:0]    ms_to_ws_bus,
    output logic                ws_allowin,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [4:0]          ws_to_ds_dest,
    output logic [DATA_W-1:0]   ws_to_ds_value,
    output logic                ws_csr,
    output logic [13:0]         csr_num,
    output logic                csr_we,
    output logic [DATA_W-1:0]   csr_wmask,
    output logic [DATA_W-1:0]   csr_wvalue,
    input  logic [DATA_W-1:0]   csr_rvalue,
    output logic                csr_ex,
    output logic                csr_ertn,
    output logic [5:0]          csr_ecode,
    output logic [8:0]          csr_esubcode,
    output logic [31:0]         csr_pc,
    input  logic [31:0]         ex_entry,
    input  logic [31:0]         era_entry,
    output logic                flush_valid,
    output logic [31:0]         flush_target,
    input  logic [HWINT_W-1:0]  hw_int_in,
    output logic [HWINT_W-1:0]  hw_int_sync,
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_wen,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [DATA_W-1:0]   debug_wb_rf_wdata
);

    localparam int PC_LSB    = 0;
    localparam int RES_LSB   = 32;
    localparam int DEST_LSB  = RES_LSB + DATA_W;
    localparam int GWE_BIT   = DEST_LSB + 5;
    localparam int CAUSE_LSB = GWE_BIT + 1;
    localparam int NUM_LSB   = CAUSE_LSB + NCAUSE;
    localparam int WMASK_LSB = NUM_LSB + 14;
    localparam int CRD_BIT   = WMASK_LSB + DATA_W;
    localparam int CWE_BIT   = CRD_BIT + 1;
    localparam int ERTN_BIT  = CWE_BIT + 1;
    localparam int FIELD_W   = ERTN_BIT + 1;
    localparam int CNT_W     = 3;
    localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(CSR_LAT);

    logic                  valid_q, valid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FIELD_W-1:0]    bus_q, bus_d;
    logic [SYNC_STAGES-1:0][HWINT_W-1:0] sync_q, sync_d;

    logic                  ertn_f;
    logic                  csr_we_f;
    logic                  csr_rd_f;
    logic [DATA_W-1:0]     wmask_f;
    logic [13:0]           num_f;
    logic [NCAUSE-1:0]     cause_f;
    logic                  gr_we_f;
    logic [4:0]            dest_f;
    logic [DATA_W-1:0]     result_f;
    logic [31:0]           pc_f;

    logic                  ws_ready_go;
    logic                  commit;
    logic                  ex;
    logic                  has_cause;
    logic                  fwd_ok;
    logic [5:0]            cause_code;
    logic [8:0]            cause_sub;
    logic                  unused_rsvd;

    // Bus bits above the field list are reserved and ignored.
    assign unused_rsvd = ^ms_to_ws_bus[BUS_W-1:FIELD_W];

    assign ertn_f   = bus_q[ERTN_BIT];
    assign csr_we_f = bus_q[CWE_BIT];
    assign csr_rd_f = bus_q[CRD_BIT];
    assign wmask_f  = bus_q[WMASK_LSB +: DATA_W];
    assign num_f    = bus_q[NUM_LSB +: 14];
    assign cause_f  = bus_q[CAUSE_LSB +: NCAUSE];
    assign gr_we_f  = bus_q[GWE_BIT];
    assign dest_f   = bus_q[DEST_LSB +: 5];
    assign result_f = bus_q[RES_LSB +: DATA_W];
    assign pc_f     = bus_q[PC_LSB +: 32];

    function automatic logic [5:0] ecode_of(input int idx);
        logic [5:0] code;
        case (idx)
            0:       code = 6'h00;
            1:       code = 6'h0b;
            2:       code = 6'h08;
            3:       code = 6'h09;
            4:       code = 6'h0c;
            5:       code = 6'h0d;
            default: code = 6'h08;
        endcase
        return code;
    endfunction

    // Scan from the top so the lowest set cause bit wins.
    always_comb begin
        cause_code = 6'h00;
        cause_sub  = 9'h000;
        for (int i = NCAUSE - 1; i >= 0; i--) begin
            if (cause_f[i]) begin
                cause_code = ecode_of(i);
                cause_sub  = (i == 6) ? 9'h001 : 9'h000;
            end
        end
    end

    assign ws_ready_go = (cnt_q == '0);
    assign ws_allowin  = ~valid_q | ws_ready_go;
    assign commit      = valid_q & ws_ready_go;
    assign has_cause   = |cause_f;
    assign ex          = commit & has_cause;

    assign rf_we    = commit & gr_we_f & ~ex;
    assign rf_waddr = dest_f;
    assign rf_wdata = csr_rd_f ? csr_rvalue : result_f;

    assign fwd_ok         = valid_q & gr_we_f & ~has_cause;
    assign ws_to_ds_dest  = fwd_ok ? dest_f : 5'd0;
    assign ws_to_ds_value = fwd_ok ? rf_wdata : '0;

    assign ws_csr     = valid_q & (csr_we_f | csr_rd_f);
    assign csr_num    = num_f;
    assign csr_we     = commit & csr_we_f & ~ex;
    assign csr_wmask  = wmask_f;
    assign csr_wvalue = result_f;
    assign csr_pc     = pc_f;

    assign csr_ex       = ex;
    assign csr_ertn     = commit & ertn_f & ~ex;
    assign csr_ecode    = ex ? cause_code : 6'h00;
    assign csr_esubcode = ex ? cause_sub : 9'h000;

    assign flush_valid  = ex | csr_ertn;
    assign flush_target = ex ? ex_entry : (csr_ertn ? era_entry : 32'h0);

    assign hw_int_sync = sync_q[SYNC_STAGES-1];
    assign sync_d      = {sync_q[SYNC_STAGES-2:0], hw_int_in};

    assign debug_wb_pc       = pc_f;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        if (ws_allowin) begin
            valid_d = ms_to_ws_valid & ~flush_valid;
        end
        if (ms_to_ws_valid & ws_allowin) begin
            bus_d = ms_to_ws_bus[FIELD_W-1:0];
            cnt_d = ms_to_ws_bus[CRD_BIT] ? CNT_LAT : '0;
        end else if (valid_q & (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            bus_q   <= '0;
            sync_q  <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            sync_q  <= sync_d;
        end
    end

endmodule

// File: tb/tb_wb_stage_gen.sv
// tb_wb_stage_gen: directed and randomized checks of wb_stage_gen against
// a transaction-level model of the writeback stage.
module tb_wb_stage_gen;

    localparam int DW  = 32;
    localparam int NC  = 7;
    localparam int HW  = 8;
    localparam int SS  = 2;
    localparam int LAT = 2;
    localparam int BW  = 87 + 2 * DW + NC;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          ms_to_ws_valid;
    logic [BW-1:0] ms_to_ws_bus;
    logic          ws_allowin;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [4:0]    ws_to_ds_dest;
    logic [DW-1:0] ws_to_ds_value;
    logic          ws_csr;
    logic [13:0]   csr_num;
    logic          csr_we;
    logic [DW-1:0] csr_wmask;
    logic [DW-1:0] csr_wvalue;
    logic [DW-1:0] csr_rvalue;
    logic          csr_ex;
    logic          csr_ertn;
    logic [5:0]    csr_ecode;
    logic [8:0]    csr_esubcode;
    logic [31:0]   csr_pc;
    logic [31:0]   ex_entry;
    logic [31:0]   era_entry;
    logic          flush_valid;
    logic [31:0]   flush_target;
    logic [HW-1:0] hw_int_in;
    logic [HW-1:0] hw_int_sync;
    logic [31:0]   debug_wb_pc;
    logic [3:0]    debug_wb_rf_wen;
    logic [4:0]    debug_wb_rf_wnum;
    logic [DW-1:0] debug_wb_rf_wdata;

    wb_stage_gen #(
        .DATA_W(DW), .NCAUSE(NC), .HWINT_W(HW),
        .SYNC_STAGES(SS), .CSR_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ws_allowin(ws_allowin),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ws_to_ds_dest(ws_to_ds_dest), .ws_to_ds_value(ws_to_ds_value),
        .ws_csr(ws_csr), .csr_num(csr_num), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .csr_rvalue(csr_rvalue), .csr_ex(csr_ex), .csr_ertn(csr_ertn),
        .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .csr_pc(csr_pc), .ex_entry(ex_entry), .era_entry(era_entry),
        .flush_valid(flush_valid), .flush_target(flush_target),
        .hw_int_in(hw_int_in), .hw_int_sync(hw_int_sync),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    typedef struct packed {
        logic          ertn;
        logic          cwe;
        logic          crd;
        logic [DW-1:0] wmask;
        logic [13:0]   num;
        logic [NC-1:0] cause;
        logic          gwe;
        logic [4:0]    dest;
        logic [DW-1:0] res;
        logic [31:0]   pc;
    } ins_t;

    int vectors    = 0;
    int miscompares = 0;

    // Model: the resident instruction and how long it has sat in WB.
    logic          m_valid;
    ins_t          m_ins;
    int            m_age;
    logic [HW-1:0] hist[$];
    logic          e_allow;
    logic          e_flush;
    logic          d_v;
    ins_t          d_ins;
    logic [HW-1:0] d_hw;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void code_of(input logic [NC-1:0] c,
                                    output logic [5:0] ec,
                                    output logic [8:0] es);
        logic [5:0] tbl [7] = '{6'h00, 6'h0b, 6'h08, 6'h09,
                                6'h0c, 6'h0d, 6'h08};
        ec = 6'h00;
        es = 9'h000;
        for (int k = 0; k < NC; k++) begin
            if (c[k]) begin
                ec = tbl[k];
                es = (k == 6) ? 9'h001 : 9'h000;
                break;
            end
        end
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.ertn  = ($urandom_range(9) == 0);
        i.cwe   = ($urandom_range(4) == 0);
        i.crd   = ($urandom_range(3) == 0);
        i.wmask = DW'($urandom);
        i.num   = 14'($urandom);
        i.cause = ($urandom_range(4) == 0) ? NC'($urandom) : '0;
        i.gwe   = ($urandom_range(9) < 7);
        i.dest  = 5'($urandom);
        i.res   = DW'($urandom);
        i.pc    = $urandom;
        return i;
    endfunction

    task automatic drive_and_check(input logic v, input ins_t i,
                                   input logic [DW-1:0] rv,
                                   input logic [31:0] ee,
                                   input logic [31:0] ea,
                                   input logic [HW-1:0] hw);
        logic ready, commit, ex, rfwe, fwd, cwe, ertn;
        logic [5:0] ec;
        logic [8:0] es;
        logic [DW-1:0] wd;
        logic [31:0] tgt;
        logic [HW-1:0] se;
        @(negedge clk);
        ms_to_ws_valid = v;
        ms_to_ws_bus   = {32'($urandom), i};
        csr_rvalue     = rv;
        ex_entry       = ee;
        era_entry      = ea;
        hw_int_in      = hw;
        d_v = v; d_ins = i; d_hw = hw;
        #1;
        ready  = !m_ins.crd || (m_age >= LAT);
        commit = m_valid && ready;
        ex     = commit && (m_ins.cause != '0);
        code_of(m_ins.cause, ec, es);
        if (!ex) begin ec = '0; es = '0; end
        rfwe   = commit && m_ins.gwe && !ex;
        wd     = m_ins.crd ? rv : m_ins.res;
        fwd    = m_valid && m_ins.gwe && (m_ins.cause == '0);
        cwe    = commit && m_ins.cwe && !ex;
        ertn   = commit && m_ins.ertn && !ex;
        e_flush = ex || ertn;
        e_allow = !m_valid || ready;
        tgt    = ex ? ee : (ertn ? ea : 32'h0);
        se     = (hist.size() >= SS) ? hist[hist.size() - SS] : '0;
        check("allowin", ws_allowin, e_allow);
        check("rf_we", rf_we, rfwe);
        check("rf_waddr", rf_waddr, m_ins.dest);
        check("rf_wdata", rf_wdata, wd);
        check("fwd_dest", ws_to_ds_dest, fwd ? m_ins.dest : 5'd0);
        check("fwd_value", ws_to_ds_value, fwd ? wd : '0);
        check("ws_csr", ws_csr, m_valid && (m_ins.cwe || m_ins.crd));
        check("csr_num", csr_num, m_ins.num);
        check("csr_we", csr_we, cwe);
        check("csr_wmask", csr_wmask, m_ins.wmask);
        check("csr_wvalue", csr_wvalue, m_ins.res);
        check("csr_ex", csr_ex, ex);
        check("csr_ertn", csr_ertn, ertn);
        check("ecode", csr_ecode, ec);
        check("esubcode", csr_esubcode, es);
        check("csr_pc", csr_pc, m_ins.pc);
        check("flush", flush_valid, e_flush);
        check("flush_tgt", flush_target, tgt);
        check("hw_sync", hw_int_sync, se);
        check("dbg_pc", debug_wb_pc, m_ins.pc);
        check("dbg_wen", debug_wb_rf_wen, {4{rfwe}});
        check("dbg_wnum", debug_wb_rf_wnum, m_ins.dest);
        check("dbg_wdata", debug_wb_rf_wdata, wd);
    endtask

    task automatic advance();
        @(posedge clk);
        if (e_allow) m_valid = d_v && !e_flush;
        if (d_v && e_allow) begin
            m_ins = d_ins;
            m_age = 0;
        end else begin
            m_age++;
        end
        hist.push_back(d_hw);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ins   = '0;
        m_age   = 0;
        hist.delete();
    endtask

    initial begin
        ins_t z, a, a2, c, e, y, r, r6;
        logic pend_v;
        ins_t pend;
        z = '0;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus   = '0;
        csr_rvalue     = '0;
        ex_entry       = '0;
        era_entry      = '0;
        hw_int_in      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_allowin", ws_allowin, 1);
        check("rst_rf_we", rf_we, 0);
        check("rst_flush", flush_valid, 0);
        check("rst_dbg_pc", debug_wb_pc, 0);
        @(negedge clk);
        reset = 1'b1;

        // Interrupt synchroniser latency
        drive_and_check(0, z, '0, '0, '0, 8'h08);
        check("hw_lat0", hw_int_sync[3], 0);
        advance();
        drive_and_check(0, z, '0, '0, '0, 8'h08);
        check("hw_lat1", hw_int_sync[3], 0);
        advance();
        drive_and_check(0, z, '0, '0, '0, 8'h08);
        check("hw_lat2", hw_int_sync[3], 1);
        advance();

        // Plain ALU op
        a = '0; a.gwe = 1; a.dest = 5; a.res = 32'h1234; a.pc = 32'h1c000000;
        drive_and_check(1, a, '0, '0, '0, '0);
        advance();
        drive_and_check(0, z, '0, '0, '0, '0);
        check("alu_we", rf_we, 1);
        check("alu_waddr", rf_waddr, 5);
        check("alu_wdata", rf_wdata, 32'h1234);
        check("alu_noflush", flush_valid, 0);
        advance();

        // CSR read stall followed by a back-to-back ALU op
        c = '0; c.crd = 1; c.gwe = 1; c.dest = 9; c.res = 32'h5555;
        c.pc = 32'h1c000010;
        a2 = '0; a2.gwe = 1; a2.dest = 6; a2.res = 32'h77; a2.pc = 32'h1c000014;
        drive_and_check(1, c, 32'hABCD, '0, '0, '0);
        advance();
        drive_and_check(1, a2, 32'hABCD, '0, '0, '0);
        check("csr_stall1", ws_allowin, 0);
        advance();
        drive_and_check(1, a2, 32'hABCD, '0, '0, '0);
        check("csr_stall2", ws_allowin, 0);
        check("csr_nowe", rf_we, 0);
        advance();
        drive_and_check(1, a2, 32'hABCD, '0, '0, '0);
        check("csr_we3", rf_we, 1);
        check("csr_rdata", rf_wdata, 32'hABCD);
        check("csr_allow3", ws_allowin, 1);
        advance();
        drive_and_check(0, z, 32'hABCD, '0, '0, '0);
        check("alu2_we", rf_we, 1);
        check("alu2_waddr", rf_waddr, 6);
        check("alu2_wdata", rf_wdata, 32'h77);
        advance();

        // Exception with two causes; younger instruction is dropped
        e = '0; e.gwe = 1; e.dest = 3; e.cause = 7'b0001010;
        e.pc = 32'h1c000020;
        y = '0; y.gwe = 1; y.dest = 7; y.res = 32'h99; y.pc = 32'h1c000024;
        drive_and_check(1, e, '0, 32'h1c008000, '0, '0);
        advance();
        drive_and_check(1, y, '0, 32'h1c008000, '0, '0);
        check("ex_pulse", csr_ex, 1);
        check("ex_ecode", csr_ecode, 6'h0b);
        check("ex_no_rf", rf_we, 0);
        check("ex_flush", flush_valid, 1);
        check("ex_target", flush_target, 32'h1c008000);
        advance();
        drive_and_check(0, z, '0, 32'h1c008000, '0, '0);
        check("young_drop", rf_we, 0);
        advance();
        drive_and_check(0, z, '0, '0, '0, '0);
        check("young_drop2", rf_we, 0);
        advance();

        // ertn, then ertn overridden by ADEM
        r = '0; r.ertn = 1; r.pc = 32'h1c000030;
        r6 = r; r6.cause = 7'b1000000;
        drive_and_check(1, r, '0, 32'h1c008000, 32'h1c000100, '0);
        advance();
        drive_and_check(0, z, '0, 32'h1c008000, 32'h1c000100, '0);
        check("ertn_pulse", csr_ertn, 1);
        check("ertn_target", flush_target, 32'h1c000100);
        advance();
        drive_and_check(1, r6, '0, 32'h1c008000, 32'h1c000100, '0);
        advance();
        drive_and_check(0, z, '0, 32'h1c008000, 32'h1c000100, '0);
        check("adem_noertn", csr_ertn, 0);
        check("adem_ex", csr_ex, 1);
        check("adem_ecode", csr_ecode, 6'h08);
        check("adem_sub", csr_esubcode, 9'h001);
        advance();

        // Randomized traffic; MEM holds an offer until it is accepted
        pend_v = 1'b0;
        pend   = '0;
        for (int n = 0; n < 400; n++) begin
            drive_and_check(pend_v, pend, DW'($urandom), $urandom,
                            $urandom, HW'($urandom));
            advance();
            if (!pend_v || e_allow) begin
                pend_v = ($urandom_range(9) < 7);
                pend   = rand_ins();
            end
        end

        // Reset in the middle of a CSR stall
        drive_and_check(1, c, 32'h1111, '0, '0, '0);
        advance();
        drive_and_check(0, z, 32'h1111, '0, '0, '0);
        check("stall_pre", ws_allowin, 0);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check("mrst_allowin", ws_allowin, 1);
        check("mrst_rf_we", rf_we, 0);
        check("mrst_wdata", rf_wdata, 0);
        check("mrst_csr", ws_csr, 0);
        check("mrst_num", csr_num, 0);
        check("mrst_ex", csr_ex, 0);
        check("mrst_flush", flush_valid, 0);
        check("mrst_dbg_pc", debug_wb_pc, 0);
        check("mrst_fwd", ws_to_ds_dest, 0);
        check("mrst_hw", hw_int_sync, 0);
        @(posedge clk);
        #1;
        check("mrst_hold_we", rf_we, 0);
        check("mrst_hold_ex", csr_ex, 0);
        check("mrst_hold_allow", ws_allowin, 1);
        @(negedge clk);
        reset = 1'b1;
        drive_and_check(0, z, '0, '0, '0, '0);
        advance();
        pend_v = 1'b0;
        for (int n = 0; n < 60; n++) begin
            drive_and_check(pend_v, pend, DW'($urandom), $urandom,
                            $urandom, '0);
            advance();
            if (!pend_v || e_allow) begin
                pend_v = ($urandom_range(9) < 7);
                pend   = rand_ins();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
